// File: rtl/core_mem_avalon_if.sv
// Avalon-MM bus between the core memory bridge (master) and the memory fabric (slave).
// Reads use the pipelined readdatavalid response.
interface core_mem_avalon_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/core_mem_avalon.sv
// Bridges a single-outstanding core memory request onto Avalon-MM with a read timeout.
// Reads abandoned on timeout are tracked so their late responses are dropped.
module core_mem_avalon #(
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_start,
    input  logic                     mem_write,
    input  logic [29:0]              mem_addr,
    input  logic [31:0]              mem_data_wr,
    output logic                     mem_ready,
    output logic [31:0]              mem_data_rd,
    output logic                     mem_fault,
    core_mem_avalon_if.master        avl
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [3:0]  stale;
    logic        is_write;
    logic        stale_dec;
    logic        timeout_hit;

    assign avl.byteenable = 4'hF;

    // Any response seen while abandoned reads are outstanding belongs to one of them.
    always_comb begin
        stale_dec   = avl.readdatavalid && (stale != 4'd0);
        timeout_hit = (state == WAIT) && !(avl.readdatavalid && (stale == 4'd0))
                      && (cnt == TIMEOUT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            stale         <= 4'd0;
            is_write      <= 1'b0;
            mem_ready     <= 1'b0;
            mem_fault     <= 1'b0;
            mem_data_rd   <= 32'd0;
            avl.read      <= 1'b0;
            avl.write     <= 1'b0;
            avl.address   <= 32'd0;
            avl.writedata <= 32'd0;
        end else begin
            mem_ready <= 1'b0;

            // Simultaneous abandon and late response leave the count unchanged.
            if (timeout_hit && !stale_dec && (stale != 4'd15))
                stale <= stale + 4'd1;
            else if (stale_dec && !timeout_hit)
                stale <= stale - 4'd1;

            case (state)
                IDLE: begin
                    if (mem_start) begin
                        is_write      <= mem_write;
                        avl.address   <= {mem_addr, 2'b00};
                        avl.writedata <= mem_data_wr;
                        avl.read      <= !mem_write;
                        avl.write     <= mem_write;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (!avl.waitrequest) begin
                        avl.read  <= 1'b0;
                        avl.write <= 1'b0;
                        if (is_write) begin
                            mem_fault <= 1'b0;
                            state     <= RESP;
                        end else begin
                            cnt   <= 8'd0;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (avl.readdatavalid && (stale == 4'd0)) begin
                        mem_data_rd <= avl.readdata;
                        mem_fault   <= 1'b0;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (timeout_hit) begin
                            mem_data_rd <= 32'd0;
                            mem_fault   <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end
                RESP: begin
                    mem_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_avalon.sv
// Bench for core_mem_avalon: behavioural Avalon slave plus scenario tasks and a
// randomized run checked against latency/data rules computed from the bus protocol.
module tb_core_mem_avalon;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_start;
    logic        mem_write;
    logic [29:0] mem_addr;
    logic [31:0] mem_data_wr;
    logic        mem_ready;
    logic [31:0] mem_data_rd;
    logic        mem_fault;

    core_mem_avalon_if avl_bus();

    core_mem_avalon #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_start   (mem_start),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_data_wr (mem_data_wr),
        .mem_ready   (mem_ready),
        .mem_data_rd (mem_data_rd),
        .mem_fault   (mem_fault),
        .avl         (avl_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int at; logic [31:0] data; } resp_t;
    typedef struct { bit wr; logic [31:0] addr; logic [31:0] wdata; int strobes; bit stable; } cmd_t;

    resp_t resp_q[$];
    cmd_t  cmd_log[$];

    // Slave behaviour knobs: waitstates per command, read latency after accept
    // (<=0 means never answer), response data, and an optional early extra pulse.
    int          ws_cfg = 0;
    int          lat_cfg = -1;
    logic [31:0] rdata_cfg = 32'd0;
    bit          extra_cfg = 1'b0;

    int          wait_left = 0;
    int          strobe_cnt = 0;
    logic [31:0] first_addr, first_wdata;
    bit          stable_flag;
    int          proto_err = 0;

    always @(negedge clk) begin
        if (avl_bus.read && avl_bus.write) proto_err++;
        if ((avl_bus.read || avl_bus.write) && avl_bus.byteenable !== 4'hF) proto_err++;
        if (avl_bus.read || avl_bus.write) begin
            if (strobe_cnt == 0) begin
                wait_left   = ws_cfg;
                first_addr  = avl_bus.address;
                first_wdata = avl_bus.writedata;
                stable_flag = 1'b1;
            end else if (avl_bus.address !== first_addr || avl_bus.writedata !== first_wdata) begin
                stable_flag = 1'b0;
            end
            strobe_cnt++;
            if (wait_left > 0) begin
                avl_bus.waitrequest = 1'b1;
                wait_left--;
            end else begin
                avl_bus.waitrequest = 1'b0;
                cmd_log.push_back('{avl_bus.write, avl_bus.address, avl_bus.writedata, strobe_cnt, stable_flag});
                if (avl_bus.read && extra_cfg) resp_q.push_back('{cyc + 1, 32'h1});
                if (avl_bus.read && lat_cfg > 0) resp_q.push_back('{cyc + lat_cfg, rdata_cfg});
                strobe_cnt = 0;
            end
        end else begin
            avl_bus.waitrequest = 1'($urandom_range(0, 1));
            strobe_cnt = 0;
        end
        if (resp_q.size() > 0 && resp_q[0].at == cyc) begin
            avl_bus.readdatavalid = 1'b1;
            avl_bus.readdata      = resp_q[0].data;
            void'(resp_q.pop_front());
        end else begin
            avl_bus.readdatavalid = 1'b0;
            avl_bus.readdata      = $urandom;
        end
    end

    // Reference: cycles from mem_start to mem_ready, from the protocol rules.
    function automatic int exp_latency(bit wr, int ws, int lat, bit timed_out);
        int accept;
        accept = 1 + ws;
        if (wr) return accept + 2;
        if (timed_out) return accept + TO + 2;
        return accept + lat + 2;
    endfunction

    task automatic run_txn(input bit wr, input logic [29:0] addr, input logic [31:0] wdata,
                           input int poke, output int t_start, output int t_ready,
                           output logic [31:0] d, output logic f, output bit single);
        @(negedge clk);
        mem_start = 1'b1; mem_write = wr; mem_addr = addr; mem_data_wr = wdata;
        t_start = cyc; t_ready = -1; d = 32'd0; f = 1'b0; single = 1'b1;
        for (int k = 1; k < 200 && t_ready < 0; k++) begin
            @(negedge clk);
            mem_start = (k == poke);
            if (k == poke) begin
                mem_write = 1'($urandom_range(0, 1)); mem_addr = 30'($urandom); mem_data_wr = $urandom;
            end
            if (mem_ready) begin t_ready = cyc; d = mem_data_rd; f = mem_fault; end
        end
        mem_start = 1'b0;
        @(negedge clk);
        if (mem_ready) single = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_start = 1'b1; mem_write = 1'b1; mem_addr = 30'h3FF; mem_data_wr = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", mem_ready); end
        checks++; if (mem_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", mem_fault); end
        checks++; if (mem_data_rd !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", mem_data_rd); end
        checks++; if (avl_bus.read !== 1'b0 || avl_bus.write !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", avl_bus.read, avl_bus.write); end
        checks++; if (avl_bus.address !== 32'd0) begin failures++; $display("FAIL reset_address got=%h exp=0", avl_bus.address); end
        checks++; if (avl_bus.writedata !== 32'd0) begin failures++; $display("FAIL reset_writedata got=%h exp=0", avl_bus.writedata); end
        checks++; if (avl_bus.byteenable !== 4'hF) begin failures++; $display("FAIL byteenable got=%h exp=f", avl_bus.byteenable); end
        rst = 1'b0; mem_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write;
        int ts, tr; logic [31:0] d; logic f; bit single;
        ws_cfg = 0; lat_cfg = -1; cmd_log.delete();
        run_txn(1'b1, 30'h100, 32'hCAFEF00D, 0, ts, tr, d, f, single);
        checks++; if (tr - ts !== 3) begin failures++; $display("FAIL write_latency got=%0d exp=3", tr - ts); end
        checks++; if (f !== 1'b0) begin failures++; $display("FAIL write_fault got=%b exp=0", f); end
        checks++; if (single !== 1'b1) begin failures++; $display("FAIL write_ready_width got=%b exp=1", single); end
        checks++; if (cmd_log.size() !== 1) begin failures++; $display("FAIL write_cmds got=%0d exp=1", cmd_log.size()); end
        if (cmd_log.size() > 0) begin
            checks++; if (cmd_log[0].addr !== 32'h400 || cmd_log[0].wr !== 1'b1) begin failures++; $display("FAIL write_cmd got=%h/%b exp=400/1", cmd_log[0].addr, cmd_log[0].wr); end
            checks++; if (cmd_log[0].wdata !== 32'hCAFEF00D || cmd_log[0].strobes !== 1) begin failures++; $display("FAIL write_beat got=%h/%0d exp=cafef00d/1", cmd_log[0].wdata, cmd_log[0].strobes); end
        end
    endtask

    task automatic test_read_wait;
        int ts, tr; logic [31:0] d; logic f; bit single; logic [29:0] a;
        a = 30'($urandom);
        ws_cfg = 4; lat_cfg = 2; rdata_cfg = 32'h12345678; cmd_log.delete();
        run_txn(1'b0, a, 32'd0, 0, ts, tr, d, f, single);
        checks++; if (tr - ts !== exp_latency(0, 4, 2, 0)) begin failures++; $display("FAIL rdwait_latency got=%0d exp=%0d", tr - ts, exp_latency(0, 4, 2, 0)); end
        checks++; if (d !== 32'h12345678 || f !== 1'b0) begin failures++; $display("FAIL rdwait_data got=%h/%b exp=12345678/0", d, f); end
        checks++; if (cmd_log.size() !== 1) begin failures++; $display("FAIL rdwait_cmds got=%0d exp=1", cmd_log.size()); end
        if (cmd_log.size() > 0) begin
            checks++; if (cmd_log[0].strobes !== 5 || cmd_log[0].stable !== 1'b1) begin failures++; $display("FAIL rdwait_strobe got=%0d/%b exp=5/1", cmd_log[0].strobes, cmd_log[0].stable); end
            checks++; if (cmd_log[0].addr !== {a, 2'b00} || cmd_log[0].wr !== 1'b0) begin failures++; $display("FAIL rdwait_addr got=%h exp=%h", cmd_log[0].addr, {a, 2'b00}); end
        end
        ws_cfg = 0;
    endtask

    task automatic test_timeout_stale;
        int ts, tr; logic [31:0] d, exp_d; logic f; bit single;
        lat_cfg = -1;
        run_txn(1'b0, 30'($urandom), 32'd0, 0, ts, tr, d, f, single);
        checks++; if (tr - ts !== exp_latency(0, 0, 0, 1)) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", tr - ts, exp_latency(0, 0, 0, 1)); end
        checks++; if (f !== 1'b1 || d !== 32'd0) begin failures++; $display("FAIL timeout_resp got=%h/%b exp=0/1", d, f); end
        resp_q.push_back('{cyc + 2, 32'hBAD});
        repeat (4) @(negedge clk);
        exp_d = $urandom; rdata_cfg = exp_d; lat_cfg = 2;
        run_txn(1'b0, 30'($urandom), 32'd0, 0, ts, tr, d, f, single);
        checks++; if (d !== exp_d || f !== 1'b0) begin failures++; $display("FAIL after_stale_data got=%h/%b exp=%h/0", d, f, exp_d); end
        checks++; if (tr - ts !== 5) begin failures++; $display("FAIL after_stale_latency got=%0d exp=5", tr - ts); end
    endtask

    task automatic test_stale_two;
        int ts, tr; logic [31:0] d; logic f; bit single;
        lat_cfg = -1;
        run_txn(1'b0, 30'($urandom), 32'd0, 0, ts, tr, d, f, single);
        checks++; if (f !== 1'b1) begin failures++; $display("FAIL stale_setup_fault got=%b exp=1", f); end
        extra_cfg = 1'b1; lat_cfg = 3; rdata_cfg = 32'h2;
        run_txn(1'b0, 30'($urandom), 32'd0, 0, ts, tr, d, f, single);
        extra_cfg = 1'b0;
        checks++; if (d !== 32'h2 || f !== 1'b0) begin failures++; $display("FAIL stale_two_data got=%h/%b exp=2/0", d, f); end
        checks++; if (tr - ts !== exp_latency(0, 0, 3, 0)) begin failures++; $display("FAIL stale_two_latency got=%0d exp=%0d", tr - ts, exp_latency(0, 0, 3, 0)); end
    endtask

    task automatic test_ignore_start;
        int ts, tr, extra; logic [31:0] d, exp_d; logic f; bit single;
        ws_cfg = 3; lat_cfg = 3;
        for (int p = 0; p < 2; p++) begin
            exp_d = $urandom; rdata_cfg = exp_d; cmd_log.delete(); extra = 0;
            run_txn(1'b0, 30'($urandom), 32'd0, (p == 0) ? 2 : 6, ts, tr, d, f, single);
            repeat (8) begin @(negedge clk); if (mem_ready) extra++; end
            checks++; if (cmd_log.size() !== 1 || extra !== 0) begin failures++; $display("FAIL ignore_start_single p=%0d cmds=%0d extra_ready=%0d exp=1/0", p, cmd_log.size(), extra); end
            checks++; if (d !== exp_d || tr - ts !== exp_latency(0, 3, 3, 0)) begin failures++; $display("FAIL ignore_start_resp p=%0d got=%h/%0d exp=%h/%0d", p, d, tr - ts, exp_d, exp_latency(0, 3, 3, 0)); end
        end
        ws_cfg = 0;
    endtask

    task automatic test_reset_mid;
        int ts, tr, extra; logic [31:0] d; logic f; bit single;
        lat_cfg = -1; extra = 0;
        @(negedge clk);
        mem_start = 1'b1; mem_write = 1'b0; mem_addr = 30'($urandom) | 30'h1; mem_data_wr = $urandom;
        @(negedge clk); mem_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_ready !== 1'b0 || mem_fault !== 1'b0 || mem_data_rd !== 32'd0) begin failures++; $display("FAIL midrst_core got=%b/%b/%h exp=0/0/0", mem_ready, mem_fault, mem_data_rd); end
        checks++; if (avl_bus.read !== 1'b0 || avl_bus.write !== 1'b0 || avl_bus.address !== 32'd0 || avl_bus.writedata !== 32'd0) begin failures++; $display("FAIL midrst_avl got=%b%b/%h/%h exp=00/0/0", avl_bus.read, avl_bus.write, avl_bus.address, avl_bus.writedata); end
        rst = 1'b0;
        repeat (10) begin @(negedge clk); if (mem_ready) extra++; end
        checks++; if (extra !== 0) begin failures++; $display("FAIL midrst_no_ready got=%0d exp=0", extra); end
        run_txn(1'b1, 30'($urandom), $urandom, 0, ts, tr, d, f, single);
        checks++; if (tr - ts !== 3 || f !== 1'b0) begin failures++; $display("FAIL midrst_write got=%0d/%b exp=3/0", tr - ts, f); end
    endtask

    task automatic test_random;
        int ts, tr, kind, ws, lat; logic [31:0] d, wd, exp_d; logic [29:0] a; logic f; bit single, wr, tmo;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2); ws = $urandom_range(0, 3); lat = $urandom_range(1, TO);
            wr = (kind == 0); tmo = (kind == 2);
            a = 30'($urandom); wd = $urandom; exp_d = $urandom;
            ws_cfg = ws; lat_cfg = tmo ? -1 : lat; rdata_cfg = exp_d; cmd_log.delete();
            run_txn(wr, a, wd, 0, ts, tr, d, f, single);
            checks++; if (tr - ts !== exp_latency(wr, ws, lat, tmo)) begin failures++; $display("FAIL rand_latency i=%0d got=%0d exp=%0d", i, tr - ts, exp_latency(wr, ws, lat, tmo)); end
            checks++; if (f !== tmo || single !== 1'b1) begin failures++; $display("FAIL rand_fault i=%0d got=%b/%b exp=%b/1", i, f, single, tmo); end
            if (!wr) begin
                checks++; if (d !== (tmo ? 32'd0 : exp_d)) begin failures++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, d, tmo ? 32'd0 : exp_d); end
            end
            checks++; if (cmd_log.size() !== 1) begin failures++; $display("FAIL rand_cmds i=%0d got=%0d exp=1", i, cmd_log.size()); end
            if (cmd_log.size() > 0) begin
                checks++; if (cmd_log[0].addr !== {a, 2'b00} || cmd_log[0].wr !== wr) begin failures++; $display("FAIL rand_cmd i=%0d got=%h/%b exp=%h/%b", i, cmd_log[0].addr, cmd_log[0].wr, {a, 2'b00}, wr); end
                checks++; if (cmd_log[0].strobes !== ws + 1 || cmd_log[0].stable !== 1'b1) begin failures++; $display("FAIL rand_strobe i=%0d got=%0d/%b exp=%0d/1", i, cmd_log[0].strobes, cmd_log[0].stable, ws + 1); end
                if (wr) begin
                    checks++; if (cmd_log[0].wdata !== wd) begin failures++; $display("FAIL rand_wdata i=%0d got=%h exp=%h", i, cmd_log[0].wdata, wd); end
                end
            end
            if (tmo) resp_q.push_back('{cyc + 1 + int'($urandom_range(0, 2)), 32'hBAD0_0000 | 32'(i)});
            repeat (6) @(negedge clk);
        end
        checks++; if (proto_err !== 0) begin failures++; $display("FAIL protocol_strobes got=%0d exp=0", proto_err); end
    endtask

    initial begin
        mem_start = 1'b0; mem_write = 1'b0; mem_addr = 30'd0; mem_data_wr = 32'd0; rst = 1'b1;
        test_reset();
        test_write();
        test_read_wait();
        test_timeout_stale();
        test_stale_two();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_mem_avalon.md
CORE_MEM_AVALON -- requirements
Module: core_mem_avalon

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles to wait for read data after a read is accepted; range 1..255.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 mem_start  in  1  one-cycle request pulse from the core.
REQ-005 mem_write  in  1  1 = write, 0 = read; sampled with mem_start.
REQ-006 mem_addr  in  30  word address (ptr); sampled with mem_start.
REQ-007 mem_data_wr  in  32  write data; sampled with mem_start.
REQ-008 mem_ready  out  1  one-cycle completion pulse to the core.
REQ-009 mem_data_rd  out  32  read data, valid only while mem_ready is high for a read.
REQ-010 mem_fault  out  1  high with mem_ready when the transaction timed out.
REQ-011 avl_address  out  32  byte address, equal to {mem_addr, 2'b00}.
REQ-012 avl_read / avl_write  out  1 each  Avalon-MM command strobes.
REQ-013 avl_writedata  out  32; avl_byteenable  out  4, constant 4'hF.
REQ-014 avl_waitrequest  in  1; avl_readdata  in  32; avl_readdatavalid  in  1 (pipelined read response).

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, REQ, WAIT, RESP.
REQ-016 IDLE + mem_start: capture addr, data and write into registers; go to REQ; assert avl_read or avl_write from the next cycle.
REQ-017 mem_start outside IDLE SHALL be ignored with no state change.
REQ-018 REQ: hold the strobe, address and writedata stable until a cycle with avl_waitrequest=0; never abort in REQ.
REQ-019 Accepted write: drop the strobe, go to RESP, and pulse mem_ready in the next cycle with mem_fault=0.
REQ-020 Accepted read: drop the strobe, go to WAIT, and clear the timeout counter to 0.
REQ-021 WAIT, avl_readdatavalid=1 and stale=0: register avl_readdata into mem_data_rd, go to RESP, and pulse mem_ready next cycle with mem_fault=0.
REQ-022 WAIT, no valid data: increment the 8-bit counter each cycle. On reaching TIMEOUT: go to RESP with mem_data_rd=0 and mem_fault=1, and increment stale.
REQ-023 stale SHALL be a 4-bit count of abandoned reads that saturates at 15.
REQ-024 Any avl_readdatavalid while stale>0 SHALL be discarded and SHALL decrement stale, in every state.
REQ-025 In WAIT with stale>0, the first readdatavalid belongs to an older read: discard it and stay in WAIT.
REQ-026 RESP: mem_ready=1 for exactly one cycle, then return to IDLE; mem_start is legal again from the following cycle.
REQ-027 Latency with zero waitstates:
  - write: mem_start at cycle T gives mem_ready at T+3;
  - read: mem_start at T with readdatavalid at T+3 gives mem_ready at T+5.
REQ-028 mem_data_rd and mem_fault SHALL hold their values until the next RESP; they are valid only with mem_ready.
REQ-029 avl_read and avl_write SHALL never be high simultaneously.
REQ-030 Strobes are asserted only in REQ; avl_read is low in IDLE, WAIT and RESP.

Reset
REQ-031 rst=1 SHALL force:
  - state=IDLE, counter=0, stale=0;
  - mem_ready=0, mem_fault=0, mem_data_rd=0;
  - avl_read=0, avl_write=0, avl_address=0, avl_writedata=0.
REQ-032 rst mid-transaction (any state) SHALL abandon the transaction silently, with no mem_ready pulse.
REQ-033 rst has priority over every other input in the same cycle.

Verification
REQ-034 Write, mem_addr=30'h100, data=32'hCAFEF00D, waitrequest=0 -> avl_write one cycle with avl_address=32'h400, then mem_ready at T+3, mem_fault=0.
REQ-035 Read, waitrequest high 4 cycles, readdata=32'h12345678 two cycles after accept -> strobe and address stable 5 cycles, then mem_ready with mem_data_rd=32'h12345678.
REQ-036 TIMEOUT=4, read accepted, no readdatavalid -> mem_ready with mem_fault=1 and mem_data_rd=0. Late readdatavalid with 32'hBAD -> discarded, stale returns to 0.
REQ-037 Stale read pending, new read issued, two readdatavalid pulses (32'h1, then 32'h2) -> core receives 32'h2 only.
REQ-038 mem_start pulsed during REQ/WAIT -> ignored, and the Avalon side shows a single transaction.
REQ-039 rst asserted in WAIT -> no mem_ready pulse, all outputs at reset values next cycle, and a subsequent write completes normally.
